// File: rtl/su_adder_param_if.sv
// Signal bundle between the PE-array sum unit and its producer / psum GBF consumer.
// The sum unit connects through the slave modport; the source side uses master.
interface su_adder_param_if #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int DEPTH                 = 32
) ();
  localparam int NPE = ROW * COL;
  localparam int GW  = $clog2(NPE) + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_BITWIDTH*NPE-1:0]     psum_out;
  logic                             pe_psum_finish;
  logic                             conv_finish;
  logic [GW-1:0]                    irrel_num;
  logic [GW-1:0]                    rel_num;
  logic                             psum_gbf_w_ready;
  logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr;
  logic                             su_add_finish;
  logic [GBF_DATA_BITWIDTH-1:0]     out_data;
  logic                             psum_gbf_w_en;
  logic [AW-1:0]                    psum_gbf_w_addr;
  logic                             psum_gbf_w_num;

  modport master (
    output psum_out, pe_psum_finish, conv_finish, irrel_num, rel_num, psum_gbf_w_ready,
    input  psum_rf_addr, su_add_finish, out_data, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num
  );

  modport slave (
    input  psum_out, pe_psum_finish, conv_finish, irrel_num, rel_num, psum_gbf_w_ready,
    output psum_rf_addr, su_add_finish, out_data, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num
  );
endinterface

// File: rtl/su_adder_param.sv
// Sums PE psums in power-of-two groups for each psum RF entry and streams the packed
// group sums into a double-banked psum GBF with a ready/valid write port.
module su_adder_param #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int DEPTH                 = 32,
  parameter int SATURATE              = 1
) (
  input  logic             clk,
  input  logic             reset,
  su_adder_param_if.slave  bus
);
  localparam int DW    = DATA_BITWIDTH;
  localparam int NPE   = ROW * COL;
  localparam int LOG   = $clog2(NPE);
  localparam int GW    = LOG + 1;
  localparam int SW    = DW + LOG;
  localparam int LANES = GBF_DATA_BITWIDTH / DW;
  localparam int RW    = PSUM_RF_ADDR_BITWIDTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = (LOG > 0) ? LOG : 1;
  localparam int LW    = (LOG > 0) ? $clog2(LOG + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_SUM   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [SW-1:0] SUM_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] rf_addr_q, rf_addr_d;
  logic [GW-1:0] word_q, word_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic          w_num_q, w_num_d;
  logic          pend_q, pend_d;
  logic [LW-1:0] lg_q, lg_d, lg_in;
  logic [GW-1:0] rel_q, rel_d, rel_in, max_rel;
  logic [GW-1:0] last_word;

  logic signed [SW-1:0] tree [LOG+1][NPE];
  logic [DW-1:0]        sum_q [NPE];

  // Level l of the tree holds the full-precision sums of aligned 2^l-PE groups.
  always_comb begin
    for (int l = 0; l <= LOG; l++)
      for (int g = 0; g < NPE; g++) tree[l][g] = '0;
    for (int p = 0; p < NPE; p++) tree[0][p] = SW'($signed(bus.psum_out[p*DW +: DW]));
    for (int l = 1; l <= LOG; l++)
      for (int g = 0; g < (NPE >> l); g++) tree[l][g] = tree[l-1][2*g] + tree[l-1][2*g+1];
  end

  // A non-power-of-two group size collapses to single-PE groups.
  always_comb begin
    lg_in = '0;
    for (int b = 0; b < GW; b++)
      if (bus.irrel_num == (GW'(1) << b)) lg_in = LW'(b);
    max_rel = GW'(NPE) >> lg_in;
    if (bus.rel_num == '0)          rel_in = GW'(1);
    else if (bus.rel_num > max_rel) rel_in = max_rel;
    else                            rel_in = bus.rel_num;
  end

  assign last_word = GW'((int'(rel_q) + LANES - 1) / LANES - 1);

  function automatic logic [DW-1:0] fit(input logic signed [SW-1:0] s);
    logic [DW-1:0] r;
    r = s[DW-1:0];
    if (SATURATE != 0) begin
      if (s > SUM_MAX)      r = SUM_MAX[DW-1:0];
      else if (s < SUM_MIN) r = SUM_MIN[DW-1:0];
    end
    return r;
  endfunction

  // NOTE: the group-sum array has no reset; SUM always rewrites it before WRITE reads it.
  always_ff @(posedge clk) begin
    if (state_q == S_SUM)
      for (int g = 0; g < NPE; g++) sum_q[g] <= fit(tree[lg_q][g]);
  end

  always_comb begin
    state_d   = state_q;
    rf_addr_d = rf_addr_q;
    word_d    = word_q;
    w_addr_d  = w_addr_q;
    w_num_d   = w_num_q;
    pend_d    = pend_q;
    lg_d      = lg_q;
    rel_d     = rel_q;
    if (bus.psum_gbf_w_en && bus.psum_gbf_w_ready)
      w_addr_d = (w_addr_q == AW'(DEPTH - 1)) ? '0 : w_addr_q + 1'b1;
    if (bus.conv_finish && state_q != S_IDLE) pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.conv_finish) begin
          w_num_d  = ~w_num_q;
          w_addr_d = '0;
        end
        if (bus.pe_psum_finish) begin
          state_d   = S_READ;
          rf_addr_d = '0;
          lg_d      = lg_in;
          rel_d     = rel_in;
        end
      end
      S_READ: state_d = S_SUM;
      S_SUM: begin
        state_d = S_WRITE;
        word_d  = '0;
      end
      S_WRITE: begin
        if (bus.psum_gbf_w_ready) begin
          if (word_q == last_word) begin
            word_d = '0;
            if (rf_addr_q == '1) begin
              state_d = S_DONE;
            end else begin
              rf_addr_d = rf_addr_q + 1'b1;
              state_d   = S_READ;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rf_addr_d = '0;
        // A bank swap requested mid-run lands only once the run has finished.
        if (pend_q || bus.conv_finish) begin
          w_num_d  = ~w_num_q;
          w_addr_d = '0;
          pend_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: blocking assignments belong in the always_comb next-state logic; the clocked block uses only <=.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rf_addr_q <= '0;
      word_q    <= '0;
      w_addr_q  <= '0;
      w_num_q   <= 1'b0;
      pend_q    <= 1'b0;
      lg_q      <= '0;
      rel_q     <= '0;
    end else begin
      state_q   <= state_d;
      rf_addr_q <= rf_addr_d;
      word_q    <= word_d;
      w_addr_q  <= w_addr_d;
      w_num_q   <= w_num_d;
      pend_q    <= pend_d;
      lg_q      <= lg_d;
      rel_q     <= rel_d;
    end
  end

  always_comb begin
    bus.out_data = '0;
    if (state_q == S_WRITE)
      for (int j = 0; j < LANES; j++)
        if (int'(word_q) * LANES + j < int'(rel_q))
          bus.out_data[j*DW +: DW] = sum_q[IW'(int'(word_q) * LANES + j)];
  end

  assign bus.psum_rf_addr    = rf_addr_q;
  assign bus.su_add_finish   = (state_q == S_DONE);
  assign bus.psum_gbf_w_en   = (state_q == S_WRITE);
  assign bus.psum_gbf_w_addr = w_addr_q;
  assign bus.psum_gbf_w_num  = w_num_q;
endmodule

// File: tb/tb_su_adder_param.sv
// Scoreboard bench: instance a (DEPTH 32, saturating) and instance b (DEPTH 4, wrapping)
// see identical stimulus; per-instance monitors compare every accepted GBF write.
module tb_su_adder_param;
  localparam int DW    = 16;
  localparam int NPE   = 256;
  localparam int GW    = 9;
  localparam int LANES = 32;
  localparam int GBF   = 512;

  typedef struct {
    logic [GBF-1:0] data;
    int             addr;
    logic           bank;
    int             rf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [DW*NPE-1:0] psum  = '0;
  logic              finish = 1'b0;
  logic              conv   = 1'b0;
  logic              ready  = 1'b1;
  logic [GW-1:0]     irrel  = 9'd1;
  logic [GW-1:0]     rel    = 9'd1;

  su_adder_param_if #(.DEPTH(32)) bus_a ();
  su_adder_param_if #(.DEPTH(4))  bus_b ();

  assign bus_a.psum_out = psum;  assign bus_b.psum_out = psum;
  assign bus_a.pe_psum_finish = finish;  assign bus_b.pe_psum_finish = finish;
  assign bus_a.conv_finish = conv;  assign bus_b.conv_finish = conv;
  assign bus_a.irrel_num = irrel;  assign bus_b.irrel_num = irrel;
  assign bus_a.rel_num = rel;  assign bus_b.rel_num = rel;
  assign bus_a.psum_gbf_w_ready = ready;  assign bus_b.psum_gbf_w_ready = ready;

  su_adder_param #(.DEPTH(32), .SATURATE(1)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  su_adder_param #(.DEPTH(4),  .SATURATE(0)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   ea_addr = 0, eb_addr = 0;
  logic ea_bank = 1'b0, eb_bank = 1'b0;
  int   total = 0, bad = 0;
  bit   prev_acc_a = 1'b0, prev_acc_b = 1'b0;

  task automatic check(input string name, input logic [GBF-1:0] act, input logic [GBF-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus_a.su_add_finish)
      check("a_finish_after_last_write", {prev_acc_a, qa.size() == 0}, 2'b11);
    if (reset && bus_a.psum_gbf_w_en && bus_a.psum_gbf_w_ready) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_write: addr %0d", bus_a.psum_gbf_w_addr);
      end else begin
        ea = qa.pop_front();
        check("a_data", bus_a.out_data, ea.data);
        check("a_addr", bus_a.psum_gbf_w_addr, ea.addr);
        check("a_bank", bus_a.psum_gbf_w_num, ea.bank);
        check("a_rf_addr", bus_a.psum_rf_addr, ea.rf);
      end
    end
    prev_acc_a = reset && bus_a.psum_gbf_w_en && bus_a.psum_gbf_w_ready;
  end

  always @(negedge clk) begin
    if (reset && bus_b.su_add_finish)
      check("b_finish_after_last_write", {prev_acc_b, qb.size() == 0}, 2'b11);
    if (reset && bus_b.psum_gbf_w_en && bus_b.psum_gbf_w_ready) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_write: addr %0d", bus_b.psum_gbf_w_addr);
      end else begin
        eb = qb.pop_front();
        check("b_data", bus_b.out_data, eb.data);
        check("b_addr", bus_b.psum_gbf_w_addr, eb.addr);
        check("b_bank", bus_b.psum_gbf_w_num, eb.bank);
        check("b_rf_addr", bus_b.psum_rf_addr, eb.rf);
      end
    end
    prev_acc_b = reset && bus_b.psum_gbf_w_en && bus_b.psum_gbf_w_ready;
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a_rf_addr"}, bus_a.psum_rf_addr, 0);
    check({tag, "_a_finish"},  bus_a.su_add_finish, 0);
    check({tag, "_a_data"},    bus_a.out_data, 0);
    check({tag, "_a_w_en"},    bus_a.psum_gbf_w_en, 0);
    check({tag, "_a_w_addr"},  bus_a.psum_gbf_w_addr, 0);
    check({tag, "_a_w_num"},   bus_a.psum_gbf_w_num, 0);
    check({tag, "_b_w_en"},    bus_b.psum_gbf_w_en, 0);
    check({tag, "_b_data"},    bus_b.out_data, 0);
    check({tag, "_b_w_addr"},  bus_b.psum_gbf_w_addr, 0);
    check({tag, "_b_w_num"},   bus_b.psum_gbf_w_num, 0);
  endtask

  // mode: 0 plain, 1 ready stall mid-entry, 2 conv_finish during WRITE,
  //       3 reset during WRITE, 4 conv_finish together with pe_psum_finish
  task automatic run(input string tag, input int irr, input int rl, input logic [15:0] pv,
                     input logic [15:0] va, input logic [15:0] vb, input int rel_eff,
                     input int mode);
    int             words, nfin;
    bit             done;
    exp_t           e;
    logic [GBF-1:0] wa, wb, hd;
    logic [4:0]     ha;
    if (mode == 4) begin
      ea_bank = ~ea_bank; eb_bank = ~eb_bank; ea_addr = 0; eb_addr = 0;
    end
    words = (rel_eff + LANES - 1) / LANES;
    for (int ent = 0; ent < 4; ent++) begin
      for (int k = 0; k < words; k++) begin
        wa = '0; wb = '0;
        for (int j = 0; j < LANES; j++)
          if (k * LANES + j < rel_eff) begin
            wa[j*DW +: DW] = va;
            wb[j*DW +: DW] = vb;
          end
        e.data = wa; e.addr = ea_addr; e.bank = ea_bank; e.rf = ent; qa.push_back(e);
        e.data = wb; e.addr = eb_addr; e.bank = eb_bank; e.rf = ent; qb.push_back(e);
        ea_addr = (ea_addr + 1) % 32;
        eb_addr = (eb_addr + 1) % 4;
      end
    end
    psum  = {NPE{pv}};
    irrel = GW'(irr);
    rel   = GW'(rl);
    @(posedge clk); #1 finish = 1'b1; conv = (mode == 4);
    @(posedge clk); #1 finish = 1'b0; conv = 1'b0;
    @(negedge clk);
    check({tag, "_read_rf_addr"}, bus_a.psum_rf_addr, 0);
    check({tag, "_read_w_en"}, bus_a.psum_gbf_w_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_sum_w_en"}, bus_a.psum_gbf_w_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_latency_w_en"}, bus_a.psum_gbf_w_en, 1);

    if (mode == 3) begin
      #1 reset = 1'b0;
      #1 check_zero_outputs({tag, "_async"});
      qa.delete(); qb.delete();
      ea_addr = 0; eb_addr = 0; ea_bank = 1'b0; eb_bank = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check({tag, "_idle_w_en"}, bus_a.psum_gbf_w_en, 0);
        check({tag, "_idle_rf_addr"}, bus_a.psum_rf_addr, 0);
      end
      return;
    end

    if (mode == 1) begin
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      hd = bus_a.out_data;
      ha = bus_a.psum_gbf_w_addr;
      check({tag, "_stall_w_en"}, bus_a.psum_gbf_w_en, 1);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        check({tag, "_stall_w_en"}, bus_a.psum_gbf_w_en, 1);
        check({tag, "_stall_data"}, bus_a.out_data, hd);
        check({tag, "_stall_addr"}, bus_a.psum_gbf_w_addr, ha);
      end
      @(posedge clk); #1 ready = 1'b1;
    end

    if (mode == 2) begin
      @(posedge clk); #1 conv = 1'b1;
      @(posedge clk); #1 conv = 1'b0;
    end

    nfin = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus_a.su_add_finish) begin
        nfin++;
        check({tag, "_bank_held_at_finish"}, bus_a.psum_gbf_w_num, ea_bank);
      end else if (nfin > 0) begin
        done = 1'b1;
      end
    end
    check({tag, "_finish_pulses"}, nfin, 1);
    check({tag, "_returned_idle"}, done, 1);
    check({tag, "_rf_addr_back_0"}, bus_a.psum_rf_addr, 0);
    check({tag, "_a_all_written"}, qa.size(), 0);
    check({tag, "_b_all_written"}, qb.size(), 0);

    if (mode == 2) begin
      ea_bank = ~ea_bank; eb_bank = ~eb_bank; ea_addr = 0; eb_addr = 0;
      check({tag, "_a_bank_after"}, bus_a.psum_gbf_w_num, ea_bank);
      check({tag, "_a_addr_after"}, bus_a.psum_gbf_w_addr, 0);
      check({tag, "_b_bank_after"}, bus_b.psum_gbf_w_num, eb_bank);
    end
  endtask

  initial begin
    #1 check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    run("base",    2,   6, 16'h0001, 16'h0002, 16'h0002,   6, 0);
    run("pos_ovf", 4,   1, 16'h7FFF, 16'h7FFF, 16'hFFFC,   1, 0);
    run("neg_ovf", 4,   1, 16'h8000, 16'h8000, 16'h0000,   1, 0);
    run("stall",   4,  64, 16'h0003, 16'h000C, 16'h000C,  64, 1);

    @(posedge clk); #1 conv = 1'b1;
    @(posedge clk); #1 conv = 1'b0;
    ea_bank = ~ea_bank; eb_bank = ~eb_bank; ea_addr = 0; eb_addr = 0;
    @(negedge clk);
    check("conv_idle_a_bank", bus_a.psum_gbf_w_num, ea_bank);
    check("conv_idle_a_addr", bus_a.psum_gbf_w_addr, 0);
    check("conv_idle_b_bank", bus_b.psum_gbf_w_num, eb_bank);
    check("conv_idle_b_addr", bus_b.psum_gbf_w_addr, 0);

    run("clamp",   3, 300, 16'hFFFF, 16'hFFFF, 16'hFFFF, 256, 0);
    run("rel0",   16,   0, 16'h0005, 16'h0050, 16'h0050,   1, 4);
    run("convw",   2,   6, 16'h0001, 16'h0002, 16'h0002,   6, 2);
    run("rst",     2,   6, 16'h0001, 16'h0002, 16'h0002,   6, 3);
    run("post",    4,  64, 16'h0002, 16'h0008, 16'h0008,  64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/su_adder_param.md
SU_ADDER_PARAM -- requirements
Module: su_adder_param

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ROW, 16, PE array rows
- COL, 16, PE array columns
- DATA_BITWIDTH, 16, psum width (DW), signed two's complement
- GBF_DATA_BITWIDTH, 512, psum GBF word width; LANES = GBF_DATA_BITWIDTH/DW
- PSUM_RF_ADDR_BITWIDTH, 2, PE psum RF address width; ENTRIES = 2^PSUM_RF_ADDR_BITWIDTH
- DEPTH, 32, psum GBF words per bank; AW = clog2(DEPTH)
- SATURATE, 1, 1 = saturating group sums, 0 = wrap-around
REQ-002 Ports (name, direction, width, meaning), one per line; NPE = ROW*COL, GW = clog2(NPE)+1:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- psum_out  in  DW*NPE  PE psums; PE p = r*COL+c at bits [p*DW +: DW]
- pe_psum_finish  in  1  PE psum RFs ready; level, sampled in IDLE
- conv_finish  in  1  convolution done; 1-cycle pulse
- irrel_num  in  GW  PEs per group; legal values 1, 2, 4, ..., NPE
- rel_num  in  GW  valid groups per RF entry; 1..NPE/irrel_num
- psum_gbf_w_ready  in  1  GBF accepts write
- psum_rf_addr  out  PSUM_RF_ADDR_BITWIDTH  RF read address
- su_add_finish  out  1  1-cycle pulse, run complete
- out_data  out  GBF_DATA_BITWIDTH  packed group sums
- psum_gbf_w_en  out  1  write valid
- psum_gbf_w_addr  out  AW  GBF write address
- psum_gbf_w_num  out  1  GBF bank select

Function
REQ-003 FSM states IDLE, READ, SUM, WRITE, DONE; irrel_num, rel_num, SATURATE settings captured on IDLE->READ; inputs held constant by the source during a run.
REQ-004 IDLE->READ when pe_psum_finish=1; psum_rf_addr=0 driven in READ.
REQ-005 psum_out valid one cycle after psum_rf_addr; SUM registers all group sums; READ->SUM->WRITE unconditional.
REQ-006 Group g = PEs g*irrel_num .. (g+1)*irrel_num-1; internal sum width DW+clog2(NPE), no overflow.
REQ-007 SATURATE=1: clamp to [-2^(DW-1), 2^(DW-1)-1]; SATURATE=0: keep low DW bits.
REQ-008 Words per entry W = ceil(rel_num/LANES); word k lane j (lane 0 at LSBs) = group k*LANES+j; lanes with index >= rel_num forced to 0.
REQ-009 WRITE: psum_gbf_w_en=1 with word k; word advances only on cycle where w_en & psum_gbf_w_ready; out_data and address held stable while ready=0.
REQ-010 After last word of an entry: if psum_rf_addr=ENTRIES-1 -> DONE, else psum_rf_addr+1 and -> READ.
REQ-011 Latency: pe_psum_finish seen in IDLE at cycle 0 -> first w_en at cycle 3 (ready held 1).
REQ-012 DONE: su_add_finish=1 for exactly one cycle, -> IDLE; psum_rf_addr returns to 0.
REQ-013 psum_gbf_w_addr increments per accepted write; wraps DEPTH-1 -> 0; persists across runs.
REQ-014 conv_finish in IDLE: toggle psum_gbf_w_num, clear psum_gbf_w_addr to 0, next cycle. conv_finish in any other state: latched, applied on DONE->IDLE transition.
REQ-015 conv_finish and pe_psum_finish in same IDLE cycle: bank toggle and address clear apply first; run writes into new bank from address 0.
REQ-016 Illegal irrel_num (0 or not power of two) treated as 1; rel_num > NPE/irrel_num clamped to NPE/irrel_num; rel_num=0 treated as 1.

Reset
REQ-017 reset=0 asynchronously forces IDLE; all outputs 0 (psum_rf_addr, su_add_finish, out_data, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num); latched conv_finish cleared; mid-run reset aborts with no further writes.

Verification
REQ-018 Defaults, all psums 1, irrel_num=2, rel_num=6, ready=1 -> 4 writes at addr 0..3, lanes 0-5 = 16'd2, lanes 6-31 = 0, su_add_finish 1 cycle after last write.
REQ-019 All psums 16'h7FFF, irrel_num=4, rel_num=1 -> lane 0 = 16'h7FFF (SATURATE=1), 16'hFFFC (SATURATE=0); all 16'h8000 with SATURATE=1 -> 16'h8000.
REQ-020 irrel_num=4, rel_num=64 -> 2 words per entry, 8 writes; ready low 3 cycles mid-entry -> w_en, out_data, w_addr held; no word lost or duplicated.
REQ-021 DEPTH=4, irrel_num=4, rel_num=64 -> addresses 0,1,2,3,0,1,2,3; then conv_finish in IDLE -> w_num=1, w_addr=0.
REQ-022 conv_finish during WRITE -> bank toggles only after su_add_finish; reset=0 during WRITE -> outputs 0 immediately, IDLE after release.
